// File: rtl/gpu_pkg.sv
// gpu_pkg -- shared definitions for the instruction-fetch path.
//   fetch_state_e   : fetch arbiter FSM states (IDLE / RESP / HOLD)
//   IMEM_WORD_SHIFT : byte address -> 32-bit word index shift
//   onehot_has_multi: true when two or more bits of a vector are set
package gpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no response outstanding
        ST_RESP = 2'd1,  // response driven straight from mem_rdata
        ST_HOLD = 2'd2   // response driven from the hold register
    } fetch_state_e;

    localparam int IMEM_WORD_SHIFT = 2;

    // v & (v-1) clears the lowest set bit; anything left means >= 2 bits set.
    function automatic logic onehot_has_multi(input logic [31:0] v);
        return |(v & (v - 32'd1));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin priority select.
//   req        in  N   request vector
//   last_grant in  GW  index of the most recently granted requester
//   gnt        out N   one-hot grant (zero when req is zero)
// Search begins at (last_grant+1) mod N and wraps, so last_grant itself
// has the lowest priority.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!found && req[(int'(last_grant) + off) % N]) begin
                gnt[(int'(last_grant) + off) % N] = 1'b1;
                found                             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter -- shares one instruction memory (1-cycle registered
// read) among NUM_CORES fetch requesters, round-robin, one fetch per cycle.
//   clk, rst_n     clock / asynchronous active-low reset
//   req_valid/addr per-core fetch request, byte PC
//   req_ready      one-hot accept (zero when no grant)
//   rsp_valid      one-hot response valid, rsp_data shared
//   rsp_ready      per-core response acceptance
//   mem_addr       word index to memory, mem_rdata its registered data
//   conflict_cnt   (only with IMEM_ARB_PERF_EN) saturating count of cycles
//                  with two or more requests pending
// Optional feature macro: IMEM_ARB_PERF_EN.
module imem_fetch_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int AW        = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [NUM_CORES-1:0][AW-1:0]  req_addr,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic [NUM_CORES-1:0]          rsp_valid,
    output logic [31:0]                   rsp_data,
    input  logic [NUM_CORES-1:0]          rsp_ready,
    output logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_rdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]                   conflict_cnt
`endif
);

    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    fetch_state_e         state_q, state_d;
    logic [GW-1:0]        last_q;    // round-robin pointer
    logic [GW-1:0]        owner_q;   // core whose response is outstanding
    logic [31:0]          hold_q;
    logic [31:0]          maddr_q;

    logic [NUM_CORES-1:0] gnt_oh;
    logic [GW-1:0]        gnt_idx;
    logic                 rsp_done;
    logic                 can_grant;
    logic                 take;
    logic [AW-1:0]        sel_word;

    rr_arbiter #(.N(NUM_CORES), .GW(GW)) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .gnt        (gnt_oh)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CORES; i++)
            if (gnt_oh[i]) gnt_idx = GW'(i);
    end

    assign rsp_done = rsp_ready[owner_q];

    // A new grant is allowed from IDLE, or from RESP when the current
    // response retires this same cycle (back-to-back). Gating with rst_n
    // keeps req_ready and mem_addr quiet while reset is held.
    always_comb begin
        can_grant = 1'b0;
        case (state_q)
            ST_IDLE: can_grant = 1'b1;
            ST_RESP: can_grant = rsp_done;
            default: can_grant = 1'b0;
        endcase
        can_grant = can_grant & rst_n;
    end

    assign take     = can_grant & (|req_valid);
    assign sel_word = req_addr[gnt_idx] >> IMEM_WORD_SHIFT;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = take ? ST_RESP : ST_IDLE;
            ST_RESP: begin
                if (!rsp_done) state_d = ST_HOLD;
                else           state_d = take ? ST_RESP : ST_IDLE;
            end
            ST_HOLD: state_d = rsp_done ? ST_IDLE : ST_HOLD;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = take ? gnt_oh : '0;
        rsp_valid = '0;
        if (state_q != ST_IDLE) rsp_valid[owner_q] = 1'b1;
        case (state_q)
            ST_RESP: rsp_data = mem_rdata;
            ST_HOLD: rsp_data = hold_q;
            default: rsp_data = '0;
        endcase
        mem_addr = take ? 32'(sel_word) : maddr_q;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= GW'(NUM_CORES - 1);
            owner_q <= '0;
            hold_q  <= '0;
            maddr_q <= '0;
        end else begin
            if (take) begin
                last_q  <= gnt_idx;
                owner_q <= gnt_idx;
                maddr_q <= 32'(sel_word);
            end
            // Memory data is only valid for one cycle; park it when stalled.
            if (state_q == ST_RESP && !rsp_done) hold_q <= mem_rdata;
        end
    end

`ifdef IMEM_ARB_PERF_EN
    logic multi_req;
    assign multi_req = onehot_has_multi(32'(req_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               conflict_cnt <= '0;
        else if (multi_req && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
module tb_imem_fetch_arbiter;
    localparam int NC = 4;
    localparam int AW = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NC-1:0]          req_valid;
    logic [NC-1:0][AW-1:0]  req_addr;
    logic [NC-1:0]          req_ready;
    logic [NC-1:0]          rsp_valid;
    logic [31:0]            rsp_data;
    logic [NC-1:0]          rsp_ready;
    logic [31:0]            mem_addr;
    logic [31:0]            mem_rdata;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0]            conflict_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    // Instruction memory model: registered read, 1-cycle latency.
    always @(posedge clk) mem_rdata <= mem[mem_addr[7:0]];

    imem_fetch_arbiter #(.NUM_CORES(NC), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
`ifdef IMEM_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive just after the edge, leave 1 time unit before checks.
    task automatic cyc(input logic [NC-1:0] v, input logic [NC-1:0] r);
        @(posedge clk); #1;
        req_valid = v;
        rsp_ready = r;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
        for (int i = 0; i < NC; i++) req_addr[i] = 32'h100 + 32'(i * 4); // words 0x40+i
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 4'hF;

        // Reset with every core requesting: all outputs quiet.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data",  rsp_data,       32'h0);
        chk("rst_mem_addr",  mem_addr,       32'h0);

        // Release: core 0 first, then 1,2,3,0 back-to-back.
        @(posedge clk); #1; rst_n = 1'b1; #1;
        chk("rr0_ready", 32'(req_ready), 32'h1);
        chk("rr0_addr",  mem_addr,       32'h40);
        chk("rr0_rv",    32'(rsp_valid), 32'h0);
        cyc(4'hF, 4'hF);
        chk("rr1_ready", 32'(req_ready), 32'h2);
        chk("rr1_addr",  mem_addr,       32'h41);
        chk("rr1_rv",    32'(rsp_valid), 32'h1);
        chk("rr1_data",  rsp_data,       32'hA500_0040);
        cyc(4'hF, 4'hF);
        chk("rr2_ready", 32'(req_ready), 32'h4);
        chk("rr2_rv",    32'(rsp_valid), 32'h2);
        chk("rr2_data",  rsp_data,       32'hA500_0041);
        cyc(4'hF, 4'hF);
        chk("rr3_ready", 32'(req_ready), 32'h8);
        chk("rr3_addr",  mem_addr,       32'h43);
        chk("rr3_rv",    32'(rsp_valid), 32'h4);
        chk("rr3_data",  rsp_data,       32'hA500_0042);
        cyc(4'hF, 4'hF);
        chk("rr4_ready", 32'(req_ready), 32'h1);
        chk("rr4_rv",    32'(rsp_valid), 32'h8);
        chk("rr4_data",  rsp_data,       32'hA500_0043);
        cyc(4'h0, 4'hF);
        chk("drain_ready", 32'(req_ready), 32'h0);
        chk("drain_rv",    32'(rsp_valid), 32'h1);
        chk("drain_data",  rsp_data,       32'hA500_0040);
        chk("drain_addr",  mem_addr,       32'h40);
        cyc(4'h0, 4'hF);
        chk("idle_rv",   32'(rsp_valid), 32'h0);
        chk("idle_data", rsp_data,       32'h0);

        // Core 2 alone at byte 0x10 -> word 4, granted every cycle.
        req_addr[2] = 32'h10;
        cyc(4'h4, 4'hF);
        chk("c2_ready", 32'(req_ready), 32'h4);
        chk("c2_addr",  mem_addr,       32'h4);
        cyc(4'h4, 4'hF);
        chk("c2b_ready", 32'(req_ready), 32'h4);
        chk("c2b_rv",    32'(rsp_valid), 32'h4);
        chk("c2b_data",  rsp_data,       32'hA500_0004);
        cyc(4'h0, 4'hF);
        chk("c2c_rv",   32'(rsp_valid), 32'h4);
        chk("c2c_data", rsp_data,       32'hA500_0004);
        cyc(4'h0, 4'hF);
        chk("c2d_rv", 32'(rsp_valid), 32'h0);
        req_addr[2] = 32'h108;

        // Core 1 granted, then stalled three cycles.
        cyc(4'h2, 4'hF);
        chk("h_grant", 32'(req_ready), 32'h2);
        chk("h_addr",  mem_addr,       32'h41);
        cyc(4'hF, 4'hD);
        chk("h_resp_rv",    32'(rsp_valid), 32'h2);
        chk("h_resp_data",  rsp_data,       32'hA500_0041);
        chk("h_resp_ready", 32'(req_ready), 32'h0);
        mem[8'h41] = 32'hDEAD_BEEF; // memory output changes; hold must not
        cyc(4'hF, 4'hD);
        chk("h1_rv",    32'(rsp_valid), 32'h2);
        chk("h1_data",  rsp_data,       32'hA500_0041);
        chk("h1_ready", 32'(req_ready), 32'h0);
        cyc(4'hF, 4'hD);
        chk("h2_data",  rsp_data,       32'hA500_0041);
        chk("h2_ready", 32'(req_ready), 32'h0);
        cyc(4'hF, 4'hF);
        chk("h3_rv",    32'(rsp_valid), 32'h2);
        chk("h3_data",  rsp_data,       32'hA500_0041);
        chk("h3_ready", 32'(req_ready), 32'h0);
        mem[8'h41] = 32'hA500_0041;
        cyc(4'hF, 4'hF);
        chk("h_next_ready", 32'(req_ready), 32'h4);
        chk("h_next_rv",    32'(rsp_valid), 32'h0);
        chk("h_next_addr",  mem_addr,       32'h42);
        cyc(4'h0, 4'hF);
        chk("h_next_rsp", rsp_data, 32'hA500_0042);
        cyc(4'h0, 4'hF);

        // Reset pulse while a response is presented.
        cyc(4'h1, 4'hF);
        chk("r_grant", 32'(req_ready), 32'h1);
        cyc(4'h0, 4'h0);
        chk("r_resp_rv", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0; #1;
        chk("r_drop_rv",   32'(rsp_valid), 32'h0);
        chk("r_drop_data", rsp_data,       32'h0);
        @(posedge clk); #1; rst_n = 1'b1; rsp_ready = 4'hF; #1;
        chk("r_post_rv", 32'(rsp_valid), 32'h0);
        cyc(4'hF, 4'hF);
        chk("r_post2_rv",    32'(rsp_valid), 32'h0);
        chk("r_post2_ready", 32'(req_ready), 32'h1);

`ifdef IMEM_ARB_PERF_EN
        @(posedge clk); #1; rst_n = 1'b0; req_valid = 4'h0; #1;
        chk("cnt_rst", conflict_cnt, 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(4'h9, 4'hF);
        cyc(4'h1, 4'hF);
        chk("cnt_five", conflict_cnt, 32'd5);
        cyc(4'h1, 4'hF);
        chk("cnt_single", conflict_cnt, 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
